// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC unit and its branch target buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: PC_BHT_EN adds a 2-bit saturating direction counter per BTB entry.
package pc_pkg;

    // Widest address the BTB entry record can hold; XLEN of the users must not exceed it.
    localparam int PC_XLEN = 32;

    // Fall-through increments for compressed / standard instructions.
    localparam int INC_RVC = 2;
    localparam int INC_STD = 4;

    // Two-bit direction counter encodings.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

    // One BTB slot. The tag is kept zero-extended to the full record width so
    // that any DEPTH can share the same record layout.
    typedef struct packed {
        logic               valid;
`ifdef PC_BHT_EN
        logic [1:0]         ctr;
`endif
        logic [PC_XLEN-1:0] tag;
        logic [PC_XLEN-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/pc_predict_if.sv
// Fetch/execute-facing signal bundle of the PC unit.
// Latency: n/a (wiring only); pc is registered, npc/pred_taken are combinational.
// Backpressure: none; pause stalls the PC, update inputs are single-cycle qualified by upd_valid.
// master: pipeline side (drives control/updates, reads pc/npc/pred_taken).
// slave : pc_predict.
interface pc_predict_if #(
    parameter int XLEN = 32
);
    logic            pause;
    logic            rvc;
    logic            flush;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            pred_taken;

    modport master (
        output pause, rvc, flush, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, npc, pred_taken
    );

    modport slave (
        input  pause, rvc, flush, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output pc, npc, pred_taken
    );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, single-port update, bulk flush.
// Latency: lookup 0 cycles; updates/flush visible to the lookup one edge later (no bypass).
// Backpressure: none; an update is accepted every cycle upd_valid is high.
// Ports: clock, reset (async active-low), flush, lk_pc -> predict/target,
//        upd_valid/upd_pc/upd_target/upd_taken (resolved branch outcome).
// Optional feature macro: PC_BHT_EN gates predictions with a 2-bit saturating counter.
module pc_btb
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic [XLEN-1:0] lk_pc,
    output logic            predict,
    output logic [XLEN-1:0] target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int IDX = $clog2(DEPTH);

    btb_entry_t mem [DEPTH];

    logic [IDX-1:0]     lk_idx;
    logic [IDX-1:0]     up_idx;
    logic [PC_XLEN-1:0] lk_tag;
    logic [PC_XLEN-1:0] up_tag;
    logic [PC_XLEN-1:0] up_tgt;
    logic               lk_hit;
    logic               up_hit;
    btb_entry_t         lk_ent;
    btb_entry_t         new_ent;

    // Bit 0 never participates: instructions are at least halfword aligned.
    assign lk_idx = lk_pc[IDX:1];
    assign up_idx = upd_pc[IDX:1];
    assign lk_tag = PC_XLEN'(lk_pc[XLEN-1:IDX+1]);
    assign up_tag = PC_XLEN'(upd_pc[XLEN-1:IDX+1]);
    assign up_tgt = PC_XLEN'({upd_target[XLEN-1:1], 1'b0});

    assign lk_ent = mem[lk_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign up_hit = mem[up_idx].valid && (mem[up_idx].tag == up_tag);
    assign target = lk_ent.target[XLEN-1:0];

`ifdef PC_BHT_EN
    assign predict = lk_hit && lk_ent.ctr[1];
`else
    assign predict = lk_hit;
`endif

    // Fresh allocation for a taken branch that missed.
    always_comb begin
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.tag    = up_tag;
        new_ent.target = up_tgt;
`ifdef PC_BHT_EN
        new_ent.ctr    = WT;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef PC_BHT_EN
                mem[i].ctr <= WNT;
`endif
            end
        end else if (flush) begin
            // Flush beats a same-cycle update: nothing is allocated.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (up_hit) begin
                    mem[up_idx].target <= up_tgt;
`ifdef PC_BHT_EN
                    mem[up_idx].ctr <= ctr_inc(mem[up_idx].ctr);
`endif
                end else begin
                    mem[up_idx] <= new_ent;
                end
            end else if (up_hit) begin
`ifdef PC_BHT_EN
                // Entry stays valid; the counter alone stops the prediction.
                mem[up_idx].ctr <= ctr_dec(mem[up_idx].ctr);
`else
                mem[up_idx].valid <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch PC register with BTB-based next-PC prediction (redirect > prediction > fall-through).
// Latency: pc is registered (npc loaded next edge); npc and pred_taken are combinational.
// Backpressure: pause holds pc; redirect still loads on the next edge even while paused.
// Ports: clock, reset (async active-low), bus (pc_predict_if.slave: pause, rvc, flush,
//        redirect/redirect_pc, upd_* update channel, pc/npc/pred_taken outputs).
// Optional feature macro: PC_BHT_EN (2-bit direction counters in the BTB).
module pc_predict
    import pc_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] RESET = '0,
    parameter int              DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    pc_predict_if.slave  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] btb_target;
    logic            btb_predict;

    pc_btb #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_btb (
        .clock      (clock),
        .reset      (reset),
        .flush      (bus.flush),
        .lk_pc      (pc_q),
        .predict    (btb_predict),
        .target     (btb_target),
        .upd_valid  (bus.upd_valid),
        .upd_pc     (bus.upd_pc),
        .upd_target (bus.upd_target),
        .upd_taken  (bus.upd_taken)
    );

    // Fall-through wraps modulo 2^XLEN.
    assign seq_pc = pc_q + (bus.rvc ? XLEN'(INC_RVC) : XLEN'(INC_STD));

    always_comb begin
        npc_d = seq_pc;
        if (bus.redirect) begin
            npc_d = {bus.redirect_pc[XLEN-1:1], 1'b0};
        end else if (btb_predict) begin
            npc_d = btb_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET;
        end else if (bus.redirect || !bus.pause) begin
            pc_q <= npc_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.npc        = npc_d;
    assign bus.pred_taken = btb_predict;

endmodule
